// File: rtl/carga_op16_if.sv
`default_nettype none
// ============================================================================
//  Module   : carga_op16_if
//  Purpose  : Byte-stream input and operand-pair output bundle of carga_op16.
//  Revision : 1.0  initial release
// ============================================================================
interface carga_op16_if;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_valid;
    logic        op_ack;
    logic [1:0]  byte_idx;

    // Loader side
    modport slave (
        input  din, din_valid, op_ack,
        output din_ready, a, b, op_valid, byte_idx
    );

    // Byte producer / operand consumer side
    modport master (
        output din, din_valid, op_ack,
        input  din_ready, a, b, op_valid, byte_idx
    );
endinterface
`default_nettype wire

// File: rtl/carga_op16.sv
`default_nettype none
// ============================================================================
//  Module   : carga_op16
//  Purpose  : Assembles two 16-bit operands from an 8-bit valid/ready stream
//             and holds them for the downstream AND gate until acknowledged.
//  Revision : 1.0  initial release
// ============================================================================
module carga_op16 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    carga_op16_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Even byte indices land in the high half when the stream is MSB-first.
    localparam logic c_MSB_FIRST = ~LSB_FIRST;

    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [1:0]  r_idx;

    logic        w_accept;
    logic        w_to_high;

    assign w_accept  = bus.din_valid && (r_state == ST_LOAD);
    assign w_to_high = r_idx[0] ^ c_MSB_FIRST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_idx   <= 2'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (!r_idx[1]) begin
                            if (w_to_high) r_a[15:8] <= bus.din;
                            else           r_a[7:0]  <= bus.din;
                        end else begin
                            if (w_to_high) r_b[15:8] <= bus.din;
                            else           r_b[7:0]  <= bus.din;
                        end
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.op_ack) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign bus.din_ready = (r_state == ST_LOAD);
    assign bus.op_valid  = (r_state == ST_HOLD);
    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.byte_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_carga_op16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_carga_op16
//  Purpose  : Scoreboard bench for carga_op16, both byte orders side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_carga_op16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       op_ack = 1'b0;

    always #5 clk = ~clk;

    carga_op16_if if1 ();
    carga_op16_if if0 ();

    assign if1.din       = din;
    assign if1.din_valid = din_valid;
    assign if1.op_ack    = op_ack;
    assign if0.din       = din;
    assign if0.din_valid = din_valid;
    assign if0.op_ack    = op_ack;

    carga_op16 #(.LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    carga_op16 #(.LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the four most recently placed bytes by stream index
    logic [7:0]  m_bytes [4];
    bit          m_hold = 1'b0;
    int          m_idx  = 0;
    bit          mon_en = 1'b0;
    int          cyc    = 0;

    logic [31:0] sb1 [$];
    logic [31:0] sb0 [$];
    int          rise1 [$];
    int          ov_hi1 = 0;
    bit          pv1 = 1'b0;
    bit          pv0 = 1'b0;

    function automatic logic [15:0] word_of(bit lsb, logic [7:0] first, logic [7:0] second);
        return lsb ? {second, first} : {first, second};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        bit         r = rst;
        bit         v = din_valid;
        bit         k = op_ack;
        logic [7:0] d = din;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_hold = 1'b0;
            m_idx  = 0;
            foreach (m_bytes[i]) m_bytes[i] = 8'h00;
        end else if (m_hold) begin
            if (k) m_hold = 1'b0;
        end else if (v) begin
            m_bytes[m_idx] = d;
            if (m_idx == 3) begin
                m_idx  = 0;
                m_hold = 1'b1;
                sb1.push_back({word_of(1'b1, m_bytes[0], m_bytes[1]), word_of(1'b1, m_bytes[2], m_bytes[3])});
                sb0.push_back({word_of(1'b0, m_bytes[0], m_bytes[1]), word_of(1'b0, m_bytes[2], m_bytes[3])});
            end else begin
                m_idx++;
            end
        end
        mon_en = 1'b1;
        #1;
    endtask

    task automatic send(logic [7:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        op_ack = 1'b1;
        tick();
        op_ack = 1'b0;
    endtask

    // Monitor: per-cycle state against the model, scoreboard pop on each new operand pair
    always @(negedge clk) begin
        if (mon_en) begin
            chk("d1_op_valid",  32'(if1.op_valid),  32'(m_hold));
            chk("d1_din_ready", 32'(if1.din_ready), 32'(!m_hold));
            chk("d1_byte_idx",  32'(if1.byte_idx),  32'(m_idx));
            chk("d1_a", 32'(if1.a), 32'(word_of(1'b1, m_bytes[0], m_bytes[1])));
            chk("d1_b", 32'(if1.b), 32'(word_of(1'b1, m_bytes[2], m_bytes[3])));
            chk("d0_op_valid",  32'(if0.op_valid),  32'(m_hold));
            chk("d0_byte_idx",  32'(if0.byte_idx),  32'(m_idx));
            chk("d0_a", 32'(if0.a), 32'(word_of(1'b0, m_bytes[0], m_bytes[1])));
            chk("d0_b", 32'(if0.b), 32'(word_of(1'b0, m_bytes[2], m_bytes[3])));
            if (if1.op_valid && !pv1) begin
                rise1.push_back(cyc);
                if (sb1.size() == 0) begin
                    n_checks++;
                    $display("FAIL d1_pair: op_valid rose with no expected pair queued");
                end else begin
                    chk("d1_pair", {if1.a, if1.b}, sb1.pop_front());
                end
            end
            if (if0.op_valid && !pv0) begin
                if (sb0.size() == 0) begin
                    n_checks++;
                    $display("FAIL d0_pair: op_valid rose with no expected pair queued");
                end else begin
                    chk("d0_pair", {if0.a, if0.b}, sb0.pop_front());
                end
            end
            if (if1.op_valid) ov_hi1++;
            pv1 = if1.op_valid;
            pv0 = if0.op_valid;
        end
    end

    initial begin
        foreach (m_bytes[i]) m_bytes[i] = 8'h00;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_a", 32'(if1.a), 32'h0);
        chk("rst_b", 32'(if1.b), 32'h0);
        chk("rst_op_valid", 32'(if1.op_valid), 32'h0);
        chk("rst_din_ready", 32'(if1.din_ready), 32'h1);
        chk("rst_byte_idx", 32'(if1.byte_idx), 32'h0);

        // Basic load, low byte first
        send(8'h34); send(8'h12); send(8'hF0); send(8'h0F);
        chk("basic_a", 32'(if1.a), 32'h1234);
        chk("basic_b", 32'(if1.b), 32'h0FF0);
        chk("basic_op_valid", 32'(if1.op_valid), 32'h1);
        chk("basic_din_ready", 32'(if1.din_ready), 32'h0);
        chk("basic_y", 32'(if1.a & if1.b), 32'h0230);

        // Hold ignores incoming bytes, then release
        din = 8'hAA;
        din_valid = 1'b1;
        repeat (3) tick();
        din_valid = 1'b0;
        chk("hold_a", 32'(if1.a), 32'h1234);
        chk("hold_b", 32'(if1.b), 32'h0FF0);
        pulse_ack();
        chk("rel_op_valid", 32'(if1.op_valid), 32'h0);
        chk("rel_din_ready", 32'(if1.din_ready), 32'h1);
        chk("rel_byte_idx", 32'(if1.byte_idx), 32'h0);

        // High byte first on the second instance
        send(8'hFF); send(8'h00); send(8'h00); send(8'hFF);
        chk("msb_a", 32'(if0.a), 32'hFF00);
        chk("msb_b", 32'(if0.b), 32'h00FF);
        chk("msb_y", 32'(if0.a & if0.b), 32'h0000);
        chk("lsb_a_same_bytes", 32'(if1.a), 32'h00FF);
        pulse_ack();

        // Idle gaps, then reset mid-operand
        send(8'h55);
        repeat (3) tick();
        send(8'h66);
        chk("gap_byte_idx", 32'(if1.byte_idx), 32'h2);
        rst = 1'b1;
        din = 8'h77;
        din_valid = 1'b1;
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        chk("midrst_a", 32'(if1.a), 32'h0);
        chk("midrst_byte_idx", 32'(if1.byte_idx), 32'h0);
        send(8'h01); send(8'h00); send(8'h01); send(8'h00);
        chk("after_rst_a", 32'(if1.a), 32'h0001);
        chk("after_rst_b", 32'(if1.b), 32'h0001);
        chk("after_rst_y", 32'(if1.a & if1.b), 32'h0001);
        pulse_ack();

        // Back-to-back with op_ack tied high
        op_ack = 1'b1;
        ov_hi1 = 0;
        rise1.delete();
        repeat (2) begin
            for (int i = 0; i < 4; i++) send(8'($urandom));
            tick();
        end
        op_ack = 1'b0;
        chk("burst_hi_cycles", 32'(ov_hi1), 32'd2);
        chk("burst_rises", 32'(rise1.size()), 32'd2);
        if (rise1.size() == 2) chk("burst_spacing", 32'(rise1[1] - rise1[0]), 32'd5);

        // Randomized traffic including occasional reset
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            din_valid = ($urandom_range(0, 9) < 7);
            din       = 8'($urandom);
            op_ack    = ($urandom_range(0, 9) < 3);
            tick();
        end
        rst = 1'b0;
        din_valid = 1'b0;
        op_ack = 1'b0;
        tick();
        tick();
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
